// File: rtl/rv32i_pipe_pkg.sv
// Shared pipeline definitions: register-address width, x0, and the hazard FSM states.
package rv32i_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Width of the internal stall/flush down-counter (parameters are limited to 1..15).
    localparam int unsigned HCU_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hcu_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID instruction's sources and the ID/EX load target.
module load_use_detect
    import rv32i_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    output logic                  load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = rs1_used && (ifid_rs1 == idex_rd);
    assign rs2_hit    = rs2_used && (ifid_rs2 == idex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_c = idex_mem_read && (idex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, mispredict flushes and data-memory freezes,
// with stall-cycle and flush-event performance counters.
module hazard_control_unit
    import rv32i_pipe_pkg::*;
#(
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  branch_mispredict,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_bubble,
    output logic                  exmem_en,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam logic [HCU_CNT_W-1:0] LS_RELOAD = HCU_CNT_W'(LOAD_USE_STALLS - 1);
    localparam logic [HCU_CNT_W-1:0] FL_RELOAD = HCU_CNT_W'(FLUSH_CYCLES - 1);

    hcu_state_e           state_q, state_d;
    logic [HCU_CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]     stall_q, flush_q;
    logic                 flush_accept;
    logic                 luh;

    load_use_detect u_luh (
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .load_use_c    (luh)
    );

    // Next-state and stage-control decode; priority is mem_busy > mispredict > load-use.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_accept = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;

        if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            if (state_q == RUN) state_d = MEM_WAIT;
        end else if (branch_mispredict) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            flush_accept = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FL_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - HCU_CNT_W'(1);
                    if (cnt_q <= HCU_CNT_W'(1)) state_d = RUN;
                end
                LOAD_STALL: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - HCU_CNT_W'(1);
                    if (cnt_q <= HCU_CNT_W'(1)) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    if (luh) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LS_RELOAD;
                        end
                    end
                end
            endcase
        end

        // Hold every stage and inject NOPs while reset is asserted.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en)       stall_q <= stall_q + CNT_W'(1);
            if (flush_accept) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule
